// File: rtl/clk_intf_monitor.sv
// rtl/clk_intf_monitor.sv - edge-rate checker for a monitored clock sampled in the reference domain
// Counts synchronized rising edges of mon_clk_i per fixed window, classifies each window, tracks lock.
module clk_intf_monitor #(
  parameter int WINDOW       = 1024,
  parameter int CNT_W        = 16,
  parameter int MIN_EDGES    = 200,
  parameter int MAX_EDGES    = 312,
  parameter int LOCK_WINDOWS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             mon_clk_i,
  output logic             meas_valid_o,
  output logic [CNT_W-1:0] meas_count_o,
  output logic             too_slow_o,
  output logic             too_fast_o,
  output logic             stopped_o,
  output logic             locked_o
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam int STK_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [STK_W-1:0] STK_FULL = STK_W'(LOCK_WINDOWS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEAS = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_w;

  logic [1:0]       state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             slow_q, slow_d;
  logic             fast_q, fast_d;
  logic             stop_q, stop_d;

  logic [CNT_W-1:0] cnt_inc_w;
  logic [31:0]      fin32_w;
  logic             is_stop_w, is_slow_w, is_fast_w, in_range_w;
  logic [STK_W-1:0] streak_inc_w;

  // Synchronizer and history keep running while disabled so the first edge after enable is genuine.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_w       = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign cnt_inc_w    = (edge_w && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
  assign fin32_w      = 32'(cnt_inc_w);
  assign is_stop_w    = (fin32_w == 32'd0);
  assign is_slow_w    = !is_stop_w && (fin32_w < 32'(MIN_EDGES));
  assign is_fast_w    = (fin32_w > 32'(MAX_EDGES));
  assign in_range_w   = !is_stop_w && !is_slow_w && !is_fast_w;
  assign streak_inc_w = (streak_q == STK_FULL) ? streak_q : streak_q + STK_W'(1);

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    edge_cnt_d = edge_cnt_q;
    streak_d   = streak_q;
    valid_d    = 1'b0;
    count_d    = count_q;
    slow_d     = slow_q;
    fast_d     = fast_q;
    stop_d     = stop_q;
    if (!en_i) begin
      state_d    = S_IDLE;
      win_d      = '0;
      edge_cnt_d = '0;
      streak_d   = '0;
      count_d    = '0;
      slow_d     = 1'b0;
      fast_d     = 1'b0;
      stop_d     = 1'b0;
    end else if (state_q == S_IDLE) begin
      state_d    = S_MEAS;
      win_d      = '0;
      edge_cnt_d = '0;
    end else if (win_q == WIN_LAST) begin
      // Closing cycle: its own edge is folded into the reported count.
      valid_d    = 1'b1;
      count_d    = cnt_inc_w;
      stop_d     = is_stop_w;
      slow_d     = is_slow_w;
      fast_d     = is_fast_w;
      win_d      = '0;
      edge_cnt_d = '0;
      if (in_range_w) begin
        streak_d = streak_inc_w;
        if (streak_inc_w == STK_FULL) state_d = S_LOCK;
      end else begin
        streak_d = '0;
        state_d  = S_MEAS;
      end
    end else begin
      win_d      = win_q + WIN_W'(1);
      edge_cnt_d = cnt_inc_w;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      edge_cnt_q <= '0;
      streak_q   <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      slow_q     <= 1'b0;
      fast_q     <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      edge_cnt_q <= edge_cnt_d;
      streak_q   <= streak_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      slow_q     <= slow_d;
      fast_q     <= fast_d;
      stop_q     <= stop_d;
    end
  end

  assign meas_valid_o = valid_q;
  assign meas_count_o = count_q;
  assign too_slow_o   = slow_q;
  assign too_fast_o   = fast_q;
  assign stopped_o    = stop_q;
  assign locked_o     = (state_q == S_LOCK);

endmodule
